// File: rtl/sum_bcd_display.sv
// -----------------------------------------------------------------------------
// sum_bcd_display
//   Display stage for the 4-bit adder datapath. Takes an unsigned binary value
//   over a valid/ready handshake, converts it to BCD with a sequential
//   shift-and-add-3 (double-dabble) pass of IN_W cycles, and drives two 9-bit
//   seven-segment patterns (units / tens). Values above 99 raise ovf and show
//   dashes on both digits.
//
// Parameters
//   IN_W       width of in_data (4..10)
//   LEAD_ZERO  1: tens digit shows "0" below 10; 0: tens digit blank (9'h000)
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-low reset
//   in_valid  in_data valid this cycle
//   in_data   unsigned binary value to display
//   in_ready  block can accept a new value (IDLE)
//   blank     force both digits to the dash pattern (display only)
//   seg_rt    units digit pattern, bit8 = dp (always 0), active-high
//   seg_lt    tens digit pattern, same encoding
//   busy      conversion in progress (CONV or LOAD)
//   ovf       last converted value > 99
// -----------------------------------------------------------------------------
module sum_bcd_display #(
    parameter int unsigned IN_W      = 8,
    parameter bit          LEAD_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    input  logic            blank,
    output logic [8:0]      seg_rt,
    output logic [8:0]      seg_lt,
    output logic            busy,
    output logic            ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    localparam logic [8:0] SEG_DASH  = 9'h040;
    localparam logic [8:0] SEG_BLANK = 9'h000;

    logic [1:0]       state;
    logic [IN_W-1:0]  bin_q;
    logic [11:0]      bcd_q;     // {hund, tens, units}
    logic             carry_q;   // sticky bit shifted out of the hundreds nibble
    logic [CNT_W-1:0] cnt_q;
    logic [8:0]       rt_q;
    logic [8:0]       lt_q;
    logic             ovf_q;

    logic [11:0]      bcd_adj;
    logic             hund_nz;
    logic [8:0]       rt_next;
    logic [8:0]       lt_next;

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [8:0] seg_code(input logic [3:0] d);
        logic [8:0] s;
        case (d)
            4'd0:    s = 9'h03f;
            4'd1:    s = 9'h006;
            4'd2:    s = 9'h05b;
            4'd3:    s = 9'h04f;
            4'd4:    s = 9'h066;
            4'd5:    s = 9'h06d;
            4'd6:    s = 9'h07d;
            4'd7:    s = 9'h007;
            4'd8:    s = 9'h07f;
            4'd9:    s = 9'h06f;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
        // Values >= 1000 (IN_W=10) carry past the hundreds nibble, so the
        // shifted-out bit is kept sticky to keep the overflow flag correct.
        hund_nz = (bcd_q[11:8] != 4'd0) || carry_q;

        if (hund_nz) begin
            rt_next = SEG_DASH;
            lt_next = SEG_DASH;
        end else begin
            rt_next = seg_code(bcd_q[3:0]);
            if (!LEAD_ZERO && (bcd_q[7:4] == 4'd0)) begin
                lt_next = SEG_BLANK;
            end else begin
                lt_next = seg_code(bcd_q[7:4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            rt_q    <= SEG_DASH;
            lt_q    <= SEG_DASH;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= in_data;
                        bcd_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= CNT_W'(IN_W);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bin_q   <= bin_q << 1;
                    bcd_q   <= {bcd_adj[10:0], bin_q[IN_W-1]};
                    carry_q <= carry_q | bcd_adj[11];
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    rt_q  <= rt_next;
                    lt_q  <= lt_next;
                    ovf_q <= hund_nz;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign ovf      = ovf_q;
    assign seg_rt   = blank ? SEG_DASH : rt_q;
    assign seg_lt   = blank ? SEG_DASH : lt_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_sum_bcd_display
//   Scoreboard bench for sum_bcd_display. Two instances share the inputs:
//   dut (LEAD_ZERO=1) and dut_nz (LEAD_ZERO=0). The stimulus pushes the
//   expected display for every accepted value; a monitor pops and compares
//   whenever busy falls (a LOAD has just completed).
// -----------------------------------------------------------------------------
module tb_sum_bcd_display;

    localparam int IN_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            blank = 1'b0;
    logic [IN_W-1:0] in_data = '0;

    logic       in_ready, busy, ovf;
    logic [8:0] seg_rt, seg_lt;
    logic       in_ready_z, busy_z, ovf_z;
    logic [8:0] seg_rt_z, seg_lt_z;

    sum_bcd_display #(.IN_W(IN_W), .LEAD_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .blank(blank), .seg_rt(seg_rt), .seg_lt(seg_lt),
        .busy(busy), .ovf(ovf)
    );

    sum_bcd_display #(.IN_W(IN_W), .LEAD_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_z), .blank(blank), .seg_rt(seg_rt_z), .seg_lt(seg_lt_z),
        .busy(busy_z), .ovf(ovf_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] rt;
        logic [8:0] lt;
        logic [8:0] lt_nz;
        logic       ov;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic [8:0] dig [10] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                             9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: a falling busy marks a completed LOAD.
    initial begin
        logic busy_prev;
        int   busy_len;
        exp_t e;
        busy_prev = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_prev = 1'b0;
                busy_len  = 0;
            end else begin
                if (busy) busy_len++;
                if (busy_prev && !busy) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_output: got rt=%0h lt=%0h, expected none", seg_rt, seg_lt);
                    end else begin
                        e = sb.pop_front();
                        check("seg_rt",   seg_rt,   e.rt);
                        check("seg_lt",   seg_lt,   e.lt);
                        check("ovf",      ovf,      e.ov);
                        check("nz_seg_rt", seg_rt_z, e.rt);
                        check("nz_seg_lt", seg_lt_z, e.lt_nz);
                        check("nz_ovf",   ovf_z,    e.ov);
                        check("latency",  cyc,      e.acc + IN_W + 1);
                        check("busy_len", busy_len, IN_W + 1);
                    end
                    busy_len = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // Called #1 after a posedge; leaves the bench #1 after a posedge.
    task automatic send(input logic [IN_W-1:0] v, input logic push,
                        input logic [8:0] rt, input logic [8:0] lt,
                        input logic [8:0] ltz, input logic ov);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got in_ready=0, expected 1");
            return;
        end
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back('{rt, lt, ltz, ov, cyc});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg_rt",   seg_rt,     9'h040);
        check("rst_seg_lt",   seg_lt,     9'h040);
        check("rst_nz_seg_lt", seg_lt_z,  9'h040);
        check("rst_in_ready", in_ready,   1'b1);
        check("rst_busy",     busy,       1'b0);
        check("rst_ovf",      ovf,        1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        send(8'd30,  1'b1, 9'h03f, 9'h04f, 9'h04f, 1'b0);
        send(8'd9,   1'b1, 9'h06f, 9'h03f, 9'h000, 1'b0);
        send(8'd10,  1'b1, 9'h03f, 9'h006, 9'h006, 1'b0);
        send(8'd0,   1'b1, 9'h03f, 9'h03f, 9'h000, 1'b0);
        send(8'd7,   1'b1, 9'h007, 9'h03f, 9'h000, 1'b0);
        send(8'd99,  1'b1, 9'h06f, 9'h06f, 9'h06f, 1'b0);
        send(8'd100, 1'b1, 9'h040, 9'h040, 9'h040, 1'b1);
        send(8'd255, 1'b1, 9'h040, 9'h040, 9'h040, 1'b1);
        send(8'd42,  1'b1, 9'h05b, 9'h066, 9'h066, 1'b0);
        drain();

        // Sweep 0..99
        for (int v = 0; v < 100; v++) begin
            send(IN_W'(v), 1'b1, dig[v % 10], dig[v / 10],
                 (v < 10) ? 9'h000 : dig[v / 10], 1'b0);
        end
        drain();

        // in_valid during CONV is ignored
        send(8'd5, 1'b1, 9'h06d, 9'h03f, 9'h000, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        repeat (IN_W + 4) @(posedge clk);
        #1;
        check("ignored_busy", busy, 1'b0);

        // blank masks the display only
        blank = 1'b1;
        #1;
        check("blank_seg_rt",   seg_rt,   9'h040);
        check("blank_seg_lt",   seg_lt,   9'h040);
        check("blank_nz_seg_lt", seg_lt_z, 9'h040);
        blank = 1'b0;
        #1;
        check("unblank_seg_rt",   seg_rt,   9'h06d);
        check("unblank_seg_lt",   seg_lt,   9'h03f);
        check("unblank_nz_seg_lt", seg_lt_z, 9'h000);
        @(posedge clk); #1;

        // Reset mid-conversion
        send(8'd45, 1'b1, 9'h06d, 9'h066, 9'h066, 1'b0);
        drain();
        send(8'd63, 1'b0, 9'h000, 9'h000, 9'h000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_seg_rt",   seg_rt,     9'h040);
        check("midrst_seg_lt",   seg_lt,     9'h040);
        check("midrst_busy",     busy,       1'b0);
        check("midrst_in_ready", in_ready,   1'b1);
        check("midrst_ovf",      ovf,        1'b0);
        check("midrst_nz_busy",  busy_z,     1'b0);
        check("midrst_nz_ready", in_ready_z, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(8'd17, 1'b1, 9'h007, 9'h006, 9'h006, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
